// File: rtl/mtm_alu_deserializer.sv
// Serial front end of the ALU: deframes 11-bit words on sin and assembles {A, B, CTL} packets.
// Optional build macro MTM_DES_TIMEOUT_EN drops partial packets after an inter-frame gap.
module mtm_alu_deserializer #(
  parameter int CLKS_PER_BIT   = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [7:0]  CTL,
  output logic        valid
);

  typedef enum logic [2:0] {IDLE, START, TYPE, PAYLOAD, STOP} state_t;

  localparam int         HALF       = CLKS_PER_BIT / 2;
  localparam logic [3:0] BIT_LOAD   = 4'(CLKS_PER_BIT - 1);
  // With HALF == 0 the detecting cycle is already the start-bit sample point.
  localparam logic [3:0] START_LOAD = (HALF == 0) ? BIT_LOAD : 4'(HALF - 1);
  localparam logic [7:0] ERR_DATA   = 8'b1100_1001;
  localparam logic [7:0] ERR_CRC    = 8'b1010_0101;
  localparam logic [7:0] CTL_IDLE   = 8'hFF;

  if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("mtm_alu_deserializer: parameter out of range");
  end

  logic        sin_meta_reg, sin_sync_reg;
  state_t      state_reg, state_next;
  logic [3:0]  wait_reg;
  logic [2:0]  bit_cnt_reg;
  logic        typ_reg;
  logic [7:0]  shift_reg;
  logic [3:0]  dcnt_reg;
  logic        err_pend_reg;
  wire  [63:0] stage_bus;

  logic        frame_start, sample, type_smp, pay_smp, stop_smp;
  logic        data_done, cmd_done, stop_ok, err_data, crc_bad, timeout_fire;
  logic [3:0]  crc_calc;

  function automatic logic [3:0] crc4(input logic [67:0] msg);
    logic [3:0] c;
    logic       fb;
    c = 4'd0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sin_meta_reg <= 1'b1;
      sin_sync_reg <= 1'b1;
    end else begin
      sin_meta_reg <= sin;
      sin_sync_reg <= sin_meta_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!sin_sync_reg) state_next = (HALF == 0) ? TYPE : START;
      START:   if (sample) state_next = sin_sync_reg ? IDLE : TYPE;
      TYPE:    if (sample) state_next = PAYLOAD;
      PAYLOAD: if (sample && bit_cnt_reg == 3'd7) state_next = STOP;
      STOP:    if (sample) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    frame_start = (state_reg == IDLE) && !sin_sync_reg;
    sample      = (state_reg != IDLE) && (wait_reg == 4'd0);
    type_smp    = sample && (state_reg == TYPE);
    pay_smp     = sample && (state_reg == PAYLOAD);
    stop_smp    = sample && (state_reg == STOP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_reg    <= 4'd0;
      bit_cnt_reg <= 3'd0;
      typ_reg     <= 1'b0;
      shift_reg   <= 8'd0;
    end else begin
      if (frame_start)
        wait_reg <= START_LOAD;
      else if (state_reg != IDLE)
        wait_reg <= (wait_reg == 4'd0) ? BIT_LOAD : wait_reg - 4'd1;
      if (type_smp) begin
        typ_reg     <= sin_sync_reg;
        bit_cnt_reg <= 3'd0;
      end else if (pay_smp) begin
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
      end
      if (pay_smp) shift_reg <= {shift_reg[6:0], sin_sync_reg};
    end
  end

  assign stop_ok   = sin_sync_reg;
  assign data_done = stop_smp && !typ_reg;
  assign cmd_done  = stop_smp && typ_reg;

  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_stage
    logic [7:0] byte_reg;
    always_ff @(posedge clk) begin
      if (!rst_n)
        byte_reg <= 8'd0;
      else if (data_done && stop_ok && dcnt_reg == 4'(gi))
        byte_reg <= shift_reg;
    end
    assign stage_bus[63-8*gi -: 8] = byte_reg;
  end

  assign crc_calc = crc4({stage_bus, 1'b1, shift_reg[6:4]});
  assign crc_bad  = (crc_calc != shift_reg[3:0]);
  // Bad command-frame stop and a set bit 7 both count as data errors.
  assign err_data = (dcnt_reg != 4'd8) || err_pend_reg || !stop_ok || shift_reg[7];

`ifdef MTM_DES_TIMEOUT_EN
  logic [15:0] gap_reg;
  logic        gap_active;
  assign gap_active   = (state_reg == IDLE) && (dcnt_reg != 4'd0) && (dcnt_reg <= 4'd8);
  assign timeout_fire = gap_active && (gap_reg == 16'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (!rst_n || !gap_active) gap_reg <= 16'd0;
    else                       gap_reg <= gap_reg + 16'd1;
  end
`else
  assign timeout_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dcnt_reg     <= 4'd0;
      err_pend_reg <= 1'b0;
    end else if (cmd_done || timeout_fire) begin
      dcnt_reg     <= 4'd0;
      err_pend_reg <= 1'b0;
    end else if (data_done) begin
      if (!stop_ok)              err_pend_reg <= 1'b1;
      else if (dcnt_reg != 4'd9) dcnt_reg     <= dcnt_reg + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      A     <= 32'd0;
      B     <= 32'd0;
      CTL   <= CTL_IDLE;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      CTL   <= CTL_IDLE;
      if (cmd_done) begin
        valid <= 1'b1;
        if (err_data)     CTL <= ERR_DATA;
        else if (crc_bad) CTL <= ERR_CRC;
        else begin
          CTL <= shift_reg;
          B   <= stage_bus[63:32];
          A   <= stage_bus[31:0];
        end
      end else if (timeout_fire) begin
        valid <= 1'b1;
        CTL   <= ERR_DATA;
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Directed bench for mtm_alu_deserializer: one instance at 1 clock/bit, one at 4 clocks/bit.
module tb_mtm_alu_deserializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sin1 = 1'b1, sin4 = 1'b1;
  logic [31:0] a1, b1, a4, b4;
  logic [7:0]  ctl1, ctl4;
  logic        valid1, valid4;
  int          checks = 0, errors = 0;
  int          vcnt1 = 0, vcnt4 = 0;

  always #5 clk = ~clk;

  mtm_alu_deserializer #(.CLKS_PER_BIT(1), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin1), .A(a1), .B(b1), .CTL(ctl1), .valid(valid1));
  mtm_alu_deserializer #(.CLKS_PER_BIT(4), .TIMEOUT_CYCLES(64)) dut4 (
    .clk(clk), .rst_n(rst_n), .sin(sin4), .A(a4), .B(b4), .CTL(ctl4), .valid(valid4));

  always @(negedge clk) begin
    if (rst_n && valid1) vcnt1++;
    if (rst_n && valid4) vcnt4++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Long-division CRC over {msg, 4'b0} with generator 10011.
  function automatic logic [3:0] crc_model(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op);
    logic [71:0] v;
    v = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (v[i]) v[i -: 5] = v[i -: 5] ^ 5'b10011;
    return v[3:0];
  endfunction

  task automatic drive_bit(input bit on4, input logic bv);
    @(negedge clk);
    if (on4) sin4 = bv; else sin1 = bv;
    repeat ((on4 ? 4 : 1) - 1) @(negedge clk);
  endtask

  task automatic send_frame(input bit on4, input logic typ, input logic [7:0] byte_v, input logic stop_v);
    drive_bit(on4, 1'b0);
    drive_bit(on4, typ);
    for (int i = 7; i >= 0; i--) drive_bit(on4, byte_v[i]);
    drive_bit(on4, stop_v);
  endtask

  task automatic send_packet(input bit on4, input logic [31:0] b, input logic [31:0] a,
                             input logic [7:0] ctl, input int ndata, input int bad_idx);
    logic [63:0] d;
    d = {b, a};
    for (int i = 0; i < ndata; i++) begin
      send_frame(on4, 1'b0, d[63-8*(i%8) -: 8], (i == bad_idx) ? 1'b0 : 1'b1);
      if (i == bad_idx) begin
        drive_bit(on4, 1'b1);
        drive_bit(on4, 1'b1);
      end
    end
    send_frame(on4, 1'b1, ctl, 1'b1);
  endtask

  task automatic wait_result(input bit on4, input string tag, input logic [7:0] exp_ctl,
                             input logic [31:0] exp_a, input logic [31:0] exp_b);
    bit got;
    int n;
    got = 0;
    n = 0;
    while (!got && n < 80) begin
      @(negedge clk);
      n++;
      if ((on4 ? valid4 : valid1) === 1'b1) got = 1;
    end
    chk($sformatf("%s_valid", tag), 64'(got), 64'd1);
    if (got) begin
      chk($sformatf("%s_ctl", tag), 64'(on4 ? ctl4 : ctl1), 64'(exp_ctl));
      chk($sformatf("%s_a", tag), 64'(on4 ? a4 : a1), 64'(exp_a));
      chk($sformatf("%s_b", tag), 64'(on4 ? b4 : b1), 64'(exp_b));
      @(negedge clk);
      chk($sformatf("%s_valid_drop", tag), 64'(on4 ? valid4 : valid1), 64'd0);
      chk($sformatf("%s_ctl_idle", tag), 64'(on4 ? ctl4 : ctl1), 64'hFF);
    end
    $display("txn %s: got=%0d ctl_exp=%02h a_exp=%08h b_exp=%08h", tag, got, exp_ctl, exp_a, exp_b);
  endtask

  initial begin
    int idle_bad;
    int v_before;
    logic [7:0] ctl_m;

    // 1: reset and idle line
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_a", 64'(a1), 64'd0);
    chk("rst_b", 64'(b1), 64'd0);
    chk("rst_ctl", 64'(ctl1), 64'hFF);
    chk("rst_valid", 64'(valid1), 64'd0);
    idle_bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ctl1 !== 8'hFF || valid1 !== 1'b0 || a1 !== 32'd0 || b1 !== 32'd0) idle_bad++;
    end
    chk("idle_200", 64'(idle_bad), 64'd0);
    $display("txn idle: 200 clocks observed");

    // 2: good packet, CRC hand-computed as 4'hC
    send_packet(1'b0, 32'h0000_0003, 32'h0000_0005, 8'h4C, 8, -1);
    wait_result(1'b0, "good", 8'h4C, 32'h5, 32'h3);

    // 3: CRC inverted
    send_packet(1'b0, 32'h0000_0003, 32'h0000_0005, 8'h43, 8, -1);
    wait_result(1'b0, "crc_bad", 8'hA5, 32'h5, 32'h3);

    // 4: short packet, then recovery
    send_packet(1'b0, 32'h0000_0003, 32'h0000_0005, 8'h4C, 6, -1);
    wait_result(1'b0, "short", 8'hC9, 32'h5, 32'h3);
    ctl_m = {1'b0, 3'b001, crc_model(32'hDEAD_BEEF, 32'h1234_5678, 3'b001)};
    send_packet(1'b0, 32'hDEAD_BEEF, 32'h1234_5678, ctl_m, 8, -1);
    wait_result(1'b0, "recover", ctl_m, 32'h1234_5678, 32'hDEAD_BEEF);

    // too many data frames, and command bit 7 set
    send_packet(1'b0, 32'h0000_0003, 32'h0000_0005, 8'h4C, 9, -1);
    wait_result(1'b0, "nine", 8'hC9, 32'h1234_5678, 32'hDEAD_BEEF);
    send_packet(1'b0, 32'h0000_0003, 32'h0000_0005, 8'hCC, 8, -1);
    wait_result(1'b0, "cmd_bit7", 8'hC9, 32'h1234_5678, 32'hDEAD_BEEF);

    // 5: framing error on the third data frame
    ctl_m = {1'b0, 3'b010, crc_model(32'hCAFE_F00D, 32'h0BAD_BEEF, 3'b010)};
    send_packet(1'b0, 32'hCAFE_F00D, 32'h0BAD_BEEF, ctl_m, 8, 2);
    wait_result(1'b0, "framing", 8'hC9, 32'h1234_5678, 32'hDEAD_BEEF);

    // 5b: one-clock glitch at 4 clocks per bit, then a real packet
    @(negedge clk);
    sin4 = 1'b0;
    @(negedge clk);
    sin4 = 1'b1;
    repeat (100) @(negedge clk);
    chk("glitch_vcnt", 64'(vcnt4), 64'd0);
    chk("glitch_ctl", 64'(ctl4), 64'hFF);
    $display("txn glitch: vcnt4=%0d", vcnt4);
    send_packet(1'b1, 32'h0000_0003, 32'h0000_0005, 8'h4C, 8, -1);
    wait_result(1'b1, "cpb4_good", 8'h4C, 32'h5, 32'h3);

    // 6: reset in the middle of a packet
    v_before = vcnt1;
    for (int i = 0; i < 4; i++) send_frame(1'b0, 1'b0, 8'hA5, 1'b1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    sin1 = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_a", 64'(a1), 64'd0);
    chk("midrst_b", 64'(b1), 64'd0);
    ctl_m = {1'b0, 3'b111, crc_model(32'h8000_0001, 32'hFFFF_FFFF, 3'b111)};
    send_packet(1'b0, 32'h8000_0001, 32'hFFFF_FFFF, ctl_m, 8, -1);
    wait_result(1'b0, "after_rst", ctl_m, 32'hFFFF_FFFF, 32'h8000_0001);
    repeat (20) @(negedge clk);
    chk("after_rst_pulses", 64'(vcnt1 - v_before), 64'd1);

`ifdef MTM_DES_TIMEOUT_EN
    for (int i = 0; i < 3; i++) send_frame(1'b0, 1'b0, 8'h3C, 1'b1);
    wait_result(1'b0, "timeout", 8'hC9, 32'hFFFF_FFFF, 32'h8000_0001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
